// File: rtl/qam16_frame_mapper_if.sv
// Purpose : bundles the bit-serial payload input and the per-symbol output bus of the 16-QAM frame mapper.
// Ports   : bit_in/bit_valid/bit_ready (serial payload handshake);
//           out_x/out_y/out_valid/frame_start/frame_done/frame_cnt (symbol stream).
// Modports: master = payload source / symbol sink, slave = the mapper.
interface qam16_frame_mapper_if #(
  parameter int OUT_W = 24
);
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [OUT_W-1:0] out_x;
  logic [OUT_W-1:0] out_y;
  logic             out_valid;
  logic             frame_start;
  logic             frame_done;
  logic [7:0]       frame_cnt;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, out_x, out_y, out_valid, frame_start, frame_done, frame_cnt
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, out_x, out_y, out_valid, frame_start, frame_done, frame_cnt
  );
endinterface

// File: rtl/qam16_frame_mapper.sv
// Purpose : packs a bit-serial payload into Gray-coded 16-QAM symbols, one 8-symbol frame at a time.
// Latency : 32nd accepted bit at edge N -> symbol 0 after edge N+1, symbol 7 after N+8, bit_ready again after N+9.
// Backpr. : bit_ready drops while a frame is emitted; the symbol stream itself cannot be stalled.
// Ports   : clk, reset (async active-low), bus (slave modport: payload handshake in, symbol stream out).
module qam16_frame_mapper #(
  parameter int SYMS_PER_FRAME = 8,
  parameter int BITS_PER_SYM   = 4,
  parameter int OUT_W          = 24
) (
  input  logic                clk,
  input  logic                reset,
  qam16_frame_mapper_if.slave bus
);

  localparam int FRAME_BITS = SYMS_PER_FRAME * BITS_PER_SYM;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int IDX_W      = $clog2(SYMS_PER_FRAME);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_SYM = IDX_W'(SYMS_PER_FRAME - 1);

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  state_t                  state;
  logic [FRAME_BITS-1:0]   buffer;
  logic [CNT_W-1:0]        bit_cnt;
  logic [IDX_W-1:0]        sym_idx;
  logic                    bit_ready_q;
  logic                    out_valid_q;
  logic                    frame_start_q;
  logic                    frame_done_q;
  logic [OUT_W-1:0]        out_x_q;
  logic [OUT_W-1:0]        out_y_q;
  logic [7:0]              frame_cnt_q;
  logic [BITS_PER_SYM-1:0] nibble;

  // Gray-coded axis level: first bit picks the sign half, second bit the
  // magnitude within it, so adjacent levels differ in one bit.
  function automatic logic [OUT_W-1:0] gray_level(input logic b_first, input logic b_second);
    logic [OUT_W-1:0] lvl;
    case ({b_first, b_second})
      2'b00:   lvl = OUT_W'(-3);
      2'b01:   lvl = OUT_W'(-1);
      2'b11:   lvl = OUT_W'(1);
      default: lvl = OUT_W'(3);
    endcase
    return lvl;
  endfunction

  // Symbol k occupies buffer bits 4k..4k+3; bit 4k was received first.
  assign nibble = buffer[{sym_idx, 2'b00} +: BITS_PER_SYM];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= COLLECT;
      buffer        <= '0;
      bit_cnt       <= '0;
      sym_idx       <= '0;
      bit_ready_q   <= 1'b1;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      frame_cnt_q   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          bit_ready_q   <= 1'b1;
          out_valid_q   <= 1'b0;
          frame_start_q <= 1'b0;
          frame_done_q  <= 1'b0;
          out_x_q       <= '0;
          out_y_q       <= '0;
          if (bus.bit_valid) begin
            buffer[bit_cnt] <= bus.bit_in;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt     <= '0;
              sym_idx     <= '0;
              bit_ready_q <= 1'b0;
              state       <= EMIT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          // frame_done_q set means the last symbol is already on the outputs;
          // this cycle retires it and reopens the payload input.
          if (frame_done_q) begin
            state         <= COLLECT;
            bit_ready_q   <= 1'b1;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            out_x_q       <= '0;
            out_y_q       <= '0;
          end else begin
            out_valid_q   <= 1'b1;
            out_x_q       <= gray_level(nibble[0], nibble[1]);
            out_y_q       <= gray_level(nibble[2], nibble[3]);
            frame_start_q <= (sym_idx == '0);
            frame_done_q  <= (sym_idx == LAST_SYM);
            sym_idx       <= sym_idx + 1'b1;
            if (sym_idx == LAST_SYM) begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.bit_ready   = bit_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_x       = out_x_q;
  assign bus.out_y       = out_y_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule
